// File: rtl/time_keeper_if.sv
`timescale 1ns/1ps
// Load-port bundle for time_keeper: load request, candidate time and reject pulse.
interface time_keeper_if;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;

    modport master (output set_valid, set_hour, set_min, set_sec, input  set_err);
    modport slave  (input  set_valid, set_hour, set_min, set_sec, output set_err);
endinterface

// File: rtl/time_keeper.sv
`timescale 1ns/1ps
// Time-of-day counter with tick prescaler, rollover strobes and BCD display digits.
// Define TIME_KEEPER_SET_EN to enable the runtime load path through set_if.
module time_keeper #(
    parameter int unsigned INIT_HOUR = 0,
    parameter int unsigned INIT_MIN  = 0,
    parameter int unsigned INIT_SEC  = 0,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_in,
    input  logic         mode_12h,
    time_keeper_if.slave set_if,
    output logic [4:0]   hour,
    output logic [5:0]   min,
    output logic [5:0]   sec,
    output logic [3:0]   Ht,
    output logic [3:0]   Hu,
    output logic [3:0]   Mt,
    output logic [3:0]   Mu,
    output logic [3:0]   St,
    output logic [3:0]   Su,
    output logic         pm,
    output logic         sec_pulse,
    output logic         min_pulse,
    output logic         day_pulse
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    generate
        if (INIT_HOUR > 23 || INIT_MIN > 59 || INIT_SEC > 59 ||
            TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_param
            $error("time_keeper: INIT_* or TICK_DIV parameter out of range");
        end
    endgenerate

    logic [4:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic [PW-1:0] r_presc;
    logic          r_sec_pulse;
    logic          r_min_pulse;
    logic          r_day_pulse;
    logic          r_set_err;

    logic          w_load;
    logic          w_bad;
    logic          w_adv;
    logic [4:0]    w_disp_hour;

`ifdef TIME_KEEPER_SET_EN
    logic w_in_range;
    assign w_in_range = (set_if.set_hour <= 5'd23) && (set_if.set_min <= 6'd59) &&
                        (set_if.set_sec <= 6'd59);
    assign w_load = set_if.set_valid && w_in_range;
    assign w_bad  = set_if.set_valid && !w_in_range;
`else
    logic w_unused_set;
    assign w_unused_set = ^{set_if.set_valid, set_if.set_hour, set_if.set_min, set_if.set_sec};
    assign w_load = 1'b0;
    assign w_bad  = 1'b0;
`endif

    // A load request (good or bad) owns the cycle; the tick in that cycle is dropped.
    assign w_adv = tick_in && !w_load && !w_bad && (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hour      <= 5'(INIT_HOUR);
            r_min       <= 6'(INIT_MIN);
            r_sec       <= 6'(INIT_SEC);
            r_presc     <= '0;
            r_sec_pulse <= 1'b0;
            r_min_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_sec_pulse <= 1'b0;
            r_min_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_set_err   <= w_bad;
            if (w_load) begin
                r_hour  <= set_if.set_hour;
                r_min   <= set_if.set_min;
                r_sec   <= set_if.set_sec;
                r_presc <= '0;
            end else if (tick_in && !w_bad) begin
                if (w_adv) begin
                    r_presc     <= '0;
                    r_sec_pulse <= 1'b1;
                    if (r_sec == 6'd59) begin
                        r_sec <= 6'd0;
                        if (r_min == 6'd59) begin
                            r_min       <= 6'd0;
                            r_min_pulse <= 1'b1;
                            if (r_hour == 5'd23) begin
                                r_hour      <= 5'd0;
                                r_day_pulse <= 1'b1;
                            end else begin
                                r_hour <= r_hour + 5'd1;
                            end
                        end else begin
                            r_min <= r_min + 6'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 6'd1;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    // 12-hour view: 0 shows as 12, 13..23 fold down by 12.
    always_comb begin
        w_disp_hour = r_hour;
        if (mode_12h) begin
            if (r_hour == 5'd0) begin
                w_disp_hour = 5'd12;
            end else if (r_hour > 5'd12) begin
                w_disp_hour = r_hour - 5'd12;
            end
        end
    end

    assign Ht = 4'(w_disp_hour / 5'd10);
    assign Hu = 4'(w_disp_hour % 5'd10);
    assign Mt = 4'(r_min / 6'd10);
    assign Mu = 4'(r_min % 6'd10);
    assign St = 4'(r_sec / 6'd10);
    assign Su = 4'(r_sec % 6'd10);
    assign pm = (r_hour >= 5'd12);

    assign hour           = r_hour;
    assign min            = r_min;
    assign sec            = r_sec;
    assign sec_pulse      = r_sec_pulse;
    assign min_pulse      = r_min_pulse;
    assign day_pulse      = r_day_pulse;
    assign set_if.set_err = r_set_err;

endmodule

// File: tb/tb_time_keeper.sv
`timescale 1ns/1ps
// Directed bench for time_keeper: three instances (A: 23:59:58 div1, B: 00:00:00 div4, C: 12:59:59 div1).
module tb_time_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tick [3];
    logic       mode [3];
    logic [4:0] hour [3];
    logic [5:0] mn   [3];
    logic [5:0] sc   [3];
    logic [3:0] ht [3], hu [3], mt [3], mu [3], st [3], su [3];
    logic       pm [3], sp [3], mp [3], dp [3];

    int errors = 0;
    int checks = 0;

    time_keeper_if sif [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        time_keeper #(
            .INIT_HOUR((g == 0) ? 23 : ((g == 1) ? 0 : 12)),
            .INIT_MIN ((g == 1) ? 0 : 59),
            .INIT_SEC ((g == 0) ? 58 : ((g == 1) ? 0 : 59)),
            .TICK_DIV ((g == 1) ? 4 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_in  (tick[g]),
            .mode_12h (mode[g]),
            .set_if   (sif[g]),
            .hour     (hour[g]),
            .min      (mn[g]),
            .sec      (sc[g]),
            .Ht       (ht[g]),
            .Hu       (hu[g]),
            .Mt       (mt[g]),
            .Mu       (mu[g]),
            .St       (st[g]),
            .Su       (su[g]),
            .pm       (pm[g]),
            .sec_pulse(sp[g]),
            .min_pulse(mp[g]),
            .day_pulse(dp[g])
        );
    end

    function automatic logic [16:0] tm(input int i);
        return {hour[i], mn[i], sc[i]};
    endfunction

    function automatic logic [23:0] dig(input int i);
        return {ht[i], hu[i], mt[i], mu[i], st[i], su[i]};
    endfunction

    function automatic logic [2:0] stb(input int i);
        return {sp[i], mp[i], dp[i]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input int i);
        tick[i] = 1'b1;
        cyc();
        tick[i] = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] et [3];
        et[0] = {5'd23, 6'd59, 6'd58};
        et[1] = 17'd0;
        et[2] = {5'd12, 6'd59, 6'd59};
        rst_n = 1'b0;
        #22;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tm(i) !== et[i]) begin
                errors++;
                $display("FAIL reset_time[%0d] got=%h exp=%h", i, tm(i), et[i]);
            end
            checks++;
            if (stb(i) !== 3'b000) begin
                errors++;
                $display("FAIL reset_strobes[%0d] got=%b exp=000", i, stb(i));
            end
        end
        checks++;
        if (dig(0) !== 24'h235958) begin
            errors++;
            $display("FAIL reset_digits_a got=%h exp=235958", dig(0));
        end
        checks++;
        if ({pm[0], pm[1], pm[2]} !== 3'b101) begin
            errors++;
            $display("FAIL reset_pm got=%b exp=101", {pm[0], pm[1], pm[2]});
        end
        checks++;
        if ({sif[0].set_err, sif[1].set_err, sif[2].set_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_set_err got=%b exp=000",
                     {sif[0].set_err, sif[1].set_err, sif[2].set_err});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_wrap();
        pulse_tick(0);
        checks++;
        if (tm(0) !== {5'd23, 6'd59, 6'd59} || stb(0) !== 3'b100) begin
            errors++;
            $display("FAIL wrap_tick1 got=%h/%b exp=%h/100", tm(0), stb(0), {5'd23, 6'd59, 6'd59});
        end
        pulse_tick(0);
        checks++;
        if (tm(0) !== 17'd0 || dig(0) !== 24'h000000) begin
            errors++;
            $display("FAIL wrap_time got=%h digits=%h exp=0", tm(0), dig(0));
        end
        checks++;
        if (stb(0) !== 3'b111) begin
            errors++;
            $display("FAIL wrap_strobes got=%b exp=111", stb(0));
        end
        cyc();
        checks++;
        if (stb(0) !== 3'b000) begin
            errors++;
            $display("FAIL wrap_strobes_clear got=%b exp=000", stb(0));
        end
        mode[0] = 1'b1;
        #1;
        checks++;
        if ({ht[0], hu[0]} !== 8'h12 || pm[0] !== 1'b0) begin
            errors++;
            $display("FAIL h12_midnight got=%h pm=%b exp=12 pm=0", {ht[0], hu[0]}, pm[0]);
        end
        mode[0] = 1'b0;
        #1;
        checks++;
        if ({ht[0], hu[0]} !== 8'h00) begin
            errors++;
            $display("FAIL h24_midnight got=%h exp=00", {ht[0], hu[0]});
        end
    endtask

    task automatic test_prescaler();
        int np;
        np = 0;
        for (int k = 0; k < 7; k++) begin
            tick[1] = 1'b1;
            cyc();
            tick[1] = 1'b0;
            np += int'(sp[1]);
            cyc();
            np += int'(sp[1]);
        end
        checks++;
        if (tm(1) !== 17'd1 || np != 1) begin
            errors++;
            $display("FAIL presc_7ticks got=%h pulses=%0d exp=00001 pulses=1", tm(1), np);
        end
        pulse_tick(1);
        checks++;
        if (sc[1] !== 6'd2 || sp[1] !== 1'b1) begin
            errors++;
            $display("FAIL presc_8th got sec=%0d sp=%b exp sec=2 sp=1", sc[1], sp[1]);
        end
        cyc();
        checks++;
        if (sp[1] !== 1'b0) begin
            errors++;
            $display("FAIL presc_pulse_width got sp=%b exp=0", sp[1]);
        end
    endtask

    task automatic test_12h();
        mode[2] = 1'b1;
        #1;
        checks++;
        if ({ht[2], hu[2]} !== 8'h12 || pm[2] !== 1'b1) begin
            errors++;
            $display("FAIL h12_noon got=%h pm=%b exp=12 pm=1", {ht[2], hu[2]}, pm[2]);
        end
        pulse_tick(2);
        checks++;
        if (tm(2) !== {5'd13, 6'd0, 6'd0} || stb(2) !== 3'b110) begin
            errors++;
            $display("FAIL min_wrap got=%h/%b exp=%h/110", tm(2), stb(2), {5'd13, 6'd0, 6'd0});
        end
        checks++;
        if (dig(2) !== 24'h010000 || pm[2] !== 1'b1) begin
            errors++;
            $display("FAIL h12_13h got=%h pm=%b exp=010000 pm=1", dig(2), pm[2]);
        end
        mode[2] = 1'b0;
        #1;
        checks++;
        if (dig(2) !== 24'h130000) begin
            errors++;
            $display("FAIL h24_13h got=%h exp=130000", dig(2));
        end
    endtask

    task automatic test_load();
`ifdef TIME_KEEPER_SET_EN
        sif[1].set_valid = 1'b1;
        sif[1].set_hour = 5'd24; sif[1].set_min = 6'd0; sif[1].set_sec = 6'd0;
        cyc();
        sif[1].set_valid = 1'b0;
        checks++;
        if (sif[1].set_err !== 1'b1 || tm(1) !== 17'd2 || stb(1) !== 3'b000) begin
            errors++;
            $display("FAIL bad_hour got err=%b t=%h stb=%b exp err=1 t=00002 stb=000",
                     sif[1].set_err, tm(1), stb(1));
        end
        cyc();
        checks++;
        if (sif[1].set_err !== 1'b0 || tm(1) !== 17'd2) begin
            errors++;
            $display("FAIL bad_err_width got err=%b t=%h exp err=0 t=00002", sif[1].set_err, tm(1));
        end
        sif[1].set_valid = 1'b1;
        sif[1].set_hour = 5'd5; sif[1].set_min = 6'd60; sif[1].set_sec = 6'd0;
        cyc();
        checks++;
        if (sif[1].set_err !== 1'b1 || tm(1) !== 17'd2) begin
            errors++;
            $display("FAIL bad_min got err=%b t=%h exp err=1 t=00002", sif[1].set_err, tm(1));
        end
        sif[1].set_hour = 5'd12; sif[1].set_min = 6'd34; sif[1].set_sec = 6'd56;
        cyc();
        sif[1].set_valid = 1'b0;
        checks++;
        if (dig(1) !== 24'h123456 || sif[1].set_err !== 1'b0 || pm[1] !== 1'b1) begin
            errors++;
            $display("FAIL good_load got=%h err=%b pm=%b exp=123456 err=0 pm=1",
                     dig(1), sif[1].set_err, pm[1]);
        end
        pulse_tick(1);
        sif[1].set_valid = 1'b1;
        sif[1].set_hour = 5'd10; sif[1].set_min = 6'd0; sif[1].set_sec = 6'd0;
        tick[1] = 1'b1;
        cyc();
        sif[1].set_valid = 1'b0;
        tick[1] = 1'b0;
        checks++;
        if (tm(1) !== {5'd10, 6'd0, 6'd0} || stb(1) !== 3'b000) begin
            errors++;
            $display("FAIL load_vs_tick got=%h stb=%b exp=%h stb=000", tm(1), stb(1), {5'd10, 6'd0, 6'd0});
        end
        for (int k = 0; k < 3; k++) pulse_tick(1);
        checks++;
        if (tm(1) !== {5'd10, 6'd0, 6'd0}) begin
            errors++;
            $display("FAIL load_presc_clear got=%h exp=%h", tm(1), {5'd10, 6'd0, 6'd0});
        end
        pulse_tick(1);
        checks++;
        if (tm(1) !== {5'd10, 6'd0, 6'd1} || sp[1] !== 1'b1) begin
            errors++;
            $display("FAIL load_presc_adv got=%h sp=%b exp=%h sp=1", tm(1), sp[1], {5'd10, 6'd0, 6'd1});
        end
`else
        sif[1].set_valid = 1'b1;
        sif[1].set_hour = 5'd12; sif[1].set_min = 6'd34; sif[1].set_sec = 6'd56;
        cyc();
        checks++;
        if (tm(1) !== 17'd2 || sif[1].set_err !== 1'b0) begin
            errors++;
            $display("FAIL load_ignored got=%h err=%b exp=00002 err=0", tm(1), sif[1].set_err);
        end
        sif[1].set_hour = 5'd24;
        cyc();
        sif[1].set_valid = 1'b0;
        checks++;
        if (tm(1) !== 17'd2 || sif[1].set_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_load_ignored got=%h err=%b exp=00002 err=0", tm(1), sif[1].set_err);
        end
        for (int k = 0; k < 4; k++) pulse_tick(1);
        checks++;
        if (tm(1) !== 17'd3 || sp[1] !== 1'b1) begin
            errors++;
            $display("FAIL tick_only got=%h sp=%b exp=00003 sp=1", tm(1), sp[1]);
        end
`endif
    endtask

    task automatic test_async_reset();
        pulse_tick(2);
        checks++;
        if (tm(2) !== {5'd13, 6'd0, 6'd1} || sp[2] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got=%h sp=%b exp=%h sp=1", tm(2), sp[2], {5'd13, 6'd0, 6'd1});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tm(2) !== {5'd12, 6'd59, 6'd59} || dig(2) !== 24'h125959 || sp[2] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_c got=%h digits=%h sp=%b exp=%h 125959 sp=0",
                     tm(2), dig(2), sp[2], {5'd12, 6'd59, 6'd59});
        end
        checks++;
        if (tm(1) !== 17'd0 || tm(0) !== {5'd23, 6'd59, 6'd58}) begin
            errors++;
            $display("FAIL async_reset_ab got b=%h a=%h exp b=00000 a=%h",
                     tm(1), tm(0), {5'd23, 6'd59, 6'd58});
        end
        for (int k = 0; k < 3; k++) begin
            tick[1] = 1'b1;
            cyc();
            tick[1] = 1'b0;
            cyc();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) pulse_tick(1);
        checks++;
        if (tm(1) !== 17'd0) begin
            errors++;
            $display("FAIL reset_tick_ignore got=%h exp=00000", tm(1));
        end
        pulse_tick(1);
        checks++;
        if (tm(1) !== 17'd1 || sp[1] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_adv got=%h sp=%b exp=00001 sp=1", tm(1), sp[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick[i] = 1'b0;
            mode[i] = 1'b0;
        end
        sif[0].set_valid = 1'b0; sif[0].set_hour = '0; sif[0].set_min = '0; sif[0].set_sec = '0;
        sif[1].set_valid = 1'b0; sif[1].set_hour = '0; sif[1].set_min = '0; sif[1].set_sec = '0;
        sif[2].set_valid = 1'b0; sif[2].set_hour = '0; sif[2].set_min = '0; sif[2].set_sec = '0;
        test_reset();
        test_wrap();
        test_prescaler();
        test_12h();
        test_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter INIT_HOUR, default 0, reset hour 0..23.
REQ-002 SHALL have parameter INIT_MIN, default 0, reset minute 0..59.
REQ-003 SHALL have parameter INIT_SEC, default 0, reset second 0..59.
REQ-004 SHALL have parameter TICK_DIV, default 1, tick_in pulses per second, range 1..65535.
REQ-005 SHALL have one clock and one reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: tick_in input 1, one-cycle time-base pulse; mode_12h input 1, 1 = 12-hour display.
REQ-007 SHALL have ports: set_valid input 1, load request; set_hour input 5; set_min input 6; set_sec input 6.
REQ-008 SHALL have ports: set_err output 1, rejected-load pulse; hour output 5, 24-hour binary; min output 6; sec output 6.
REQ-009 SHALL have ports: Ht, Hu, Mt, Mu, St, Su outputs, 4 bits each, BCD display digits; pm output 1.
REQ-010 SHALL have ports: sec_pulse, min_pulse, day_pulse outputs, 1 bit each, rollover strobes.

Function
REQ-011 SHALL hold an internal prescaler of 0..TICK_DIV-1; on tick_in at TICK_DIV-1 it clears and a second advance occurs, otherwise it increments.
REQ-012 SHALL, on second advance, wrap sec 59->0 with min+1, min 59->0 with hour+1, and hour 23->0; no other fields change.
REQ-013 SHALL assert sec_pulse for one cycle on each second advance, min_pulse when min wraps 59->0, and day_pulse on 23:59:59->00:00:00, all in the same cycle the counters update.
REQ-014 SHALL accept a load when set_valid=1 and set_hour<=23, set_min<=59, set_sec<=59; registers take the set values next cycle and the prescaler clears.
REQ-015 SHALL, on set_valid=1 with any field out of range, leave time unchanged and pulse set_err for one cycle; there are no strobes.
REQ-016 SHALL, on an accepted load and second advance in the same cycle, apply the load, drop the advance, and raise no strobes.
REQ-017 SHALL keep hour 24-hour internally; mode_12h affects only Ht/Hu; pm = (hour>=12) in both modes.
REQ-018 SHALL, in 12-hour mode, display hour 0 as 12, 1..12 unchanged, and 13..23 as hour-12.
REQ-019 SHALL derive the BCD digits combinationally from the registered values, with zero latency and no leading-zero suppression.
REQ-020 SHALL ignore tick_in pulses while rst_n=0; the first tick after release counts as prescaler step one.

Reset
REQ-021 SHALL, on rst_n low, asynchronously set hour=INIT_HOUR, min=INIT_MIN, sec=INIT_SEC, prescaler=0, and all strobes and set_err to 0.
REQ-022 SHALL deassert reset synchronously; a reset during a set_valid cycle discards the load.
REQ-023 SHALL fail elaboration on any out-of-range INIT_* or TICK_DIV.

Configuration
REQ-024 SHALL compile the load interface only when macro TIME_KEEPER_SET_EN is defined.
REQ-025 SHALL, without TIME_KEEPER_SET_EN, keep the set_* ports, ignore set_valid, tie set_err to 0, and change time only by ticking.

Verification
REQ-026 SHALL cover wrap: TICK_DIV=1, load 23:59:58, 2 ticks -> 00:00:00, with sec_pulse, min_pulse and day_pulse high together on tick 2.
REQ-027 SHALL cover prescaler: TICK_DIV=4, 7 ticks -> sec=1, prescaler=3; 8th tick -> sec=2, one sec_pulse.
REQ-028 SHALL cover bad load: set 24:00:00 -> set_err 1 cycle, time unchanged; set 12:34:56 -> Ht/Hu/Mt/Mu/St/Su = 1/2/3/4/5/6 next cycle.
REQ-029 SHALL cover 12-hour mode: mode_12h=1 at hour 0 -> Ht/Hu=1/2, pm=0; at hour 13 -> 0/1, pm=1; at hour 12 -> 1/2, pm=1.
REQ-030 SHALL cover load vs tick: load 10:00:00 with tick_in in the same cycle -> 10:00:00, no strobes, prescaler 0.
REQ-031 SHALL cover async reset: rst_n low mid-count without a clock edge -> outputs at INIT values immediately.
